// File: rtl/alu4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu4                                                         |
// | Description : 4-bit registered add/subtract ALU with zero, carry/borrow,   |
// |               sign and (optionally) signed-overflow flags. Each valid     |
// |               operation completes on the rising edge that samples it.     |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   1  clock, all state updates on the rising edge            |
// |   rst_n      in   1  asynchronous active-low reset (release assumed sync)   |
// |   ctl        in   2  0 uadd, 1 usub, 2 sadd, 3 ssub                         |
// |   in1        in   4  operand A                                              |
// |   in2        in   4  operand B                                              |
// |   in_valid   in   1  operands / opcode valid this cycle                     |
// |   out        out  4  registered result                                      |
// |   ZF         out  1  registered zero flag                                   |
// |   CF         out  1  registered carry / borrow / overflow flag              |
// |   SF         out  1  registered sign flag (raw result MSB)                  |
// |   VF         out  1  registered signed overflow (only with ALU4_VF_EN)      |
// |   out_valid  out  1  result and flags valid                                 |
// +----------------------------------------------------------------------------+
// | Configuration                                                              |
// |   ALU4_VF_EN defined   : VF port present, CF is always carry/borrow.        |
// |   ALU4_VF_EN undefined : no VF port, CF carries overflow for ctl=2/3.       |
// +----------------------------------------------------------------------------+
module alu4 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] ctl,
   input  logic [3:0] in1,
   input  logic [3:0] in2,
   input  logic       in_valid,
   output logic [3:0] out,
   output logic       ZF,
   output logic       CF,
   output logic       SF,
`ifdef ALU4_VF_EN
   output logic       VF,
`endif
   output logic       out_valid
);

   // ------------------------------------------------------------------------
   // Datapath: a single 5-bit adder serves all four opcodes. Subtraction is
   // formed as in1 + ~in2 + 1, so ctl=1 and ctl=3 produce the same pattern.
   // ------------------------------------------------------------------------
   logic       is_sub;
   logic [3:0] b_op;
   logic [4:0] sum5;
   logic [3:0] res;
   logic       carry;
   logic       borrow;
   logic       ovf;
   logic       unsigned_c;
   logic       flag_c;
   logic       flag_v;

   always_comb begin
      is_sub     = ctl[0];
      b_op       = is_sub ? ~in2 : in2;
      sum5       = {1'b0, in1} + {1'b0, b_op} + {4'b0000, is_sub};
      res        = sum5[3:0];
      carry      = sum5[4];
      // With the inverted-operand form, a carry out means in1 >= in2, so the
      // borrow is its complement.
      borrow     = ~sum5[4];
      // Two's-complement overflow: both adder inputs share a sign and the
      // result sign differs. Using b_op covers subtraction as well.
      ovf        = (in1[3] == b_op[3]) && (res[3] != in1[3]);
      unsigned_c = is_sub ? borrow : carry;
`ifdef ALU4_VF_EN
      flag_c     = unsigned_c;
      flag_v     = ctl[1] & ovf;
`else
      // Without a dedicated VF output the signed opcodes report overflow on CF.
      flag_c     = ctl[1] ? ovf : unsigned_c;
      flag_v     = 1'b0;
`endif
   end

   // ------------------------------------------------------------------------
   // Output register next-state: load on a valid op, otherwise hold.
   // out_valid simply tracks in_valid one cycle later.
   // ------------------------------------------------------------------------
   logic [3:0] out_d,       out_q;
   logic       zf_d,        zf_q;
   logic       cf_d,        cf_q;
   logic       sf_d,        sf_q;
   logic       out_valid_d, out_valid_q;
`ifdef ALU4_VF_EN
   logic       vf_d,        vf_q;
`endif

   always_comb begin
      out_d       = out_q;
      zf_d        = zf_q;
      cf_d        = cf_q;
      sf_d        = sf_q;
`ifdef ALU4_VF_EN
      vf_d        = vf_q;
`endif
      out_valid_d = in_valid;
      if (in_valid) begin
         out_d = res;
         zf_d  = (res == 4'd0);
         cf_d  = flag_c;
         sf_d  = res[3];
`ifdef ALU4_VF_EN
         vf_d  = flag_v;
`endif
      end
   end

`ifndef ALU4_VF_EN
   // flag_v has no consumer in this build; fold it into a dead AND so the
   // signal stays defined in both configurations without a dangling wire.
   logic unused_flag_v;
   assign unused_flag_v = flag_v & 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= 4'd0;
         zf_q        <= 1'b0;
         cf_q        <= 1'b0;
         sf_q        <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef ALU4_VF_EN
         vf_q        <= 1'b0;
`endif
      end else begin
         out_q       <= out_d;
         zf_q        <= zf_d;
         cf_q        <= cf_d;
         sf_q        <= sf_d;
         out_valid_q <= out_valid_d;
`ifdef ALU4_VF_EN
         vf_q        <= vf_d;
`endif
      end
   end

   assign out       = out_q;
   assign ZF        = zf_q;
   assign CF        = cf_q;
   assign SF        = sf_q;
   assign out_valid = out_valid_q;
`ifdef ALU4_VF_EN
   assign VF        = vf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu4                                                      |
// | Description : Self-checking bench for alu4 against an integer reference   |
// |               model; directed cases, reset behaviour, random traffic.     |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu4;

   logic       clk;
   logic       rst_n;
   logic [1:0] ctl;
   logic [3:0] in1;
   logic [3:0] in2;
   logic       in_valid;
   logic [3:0] out;
   logic       zf;
   logic       cf;
   logic       sf;
   logic       out_valid;
   logic       vf;

   int total = 0;
   int bad   = 0;

   // expected register contents
   logic [3:0] exp_out = 4'd0;
   logic       exp_zf  = 1'b0;
   logic       exp_cf  = 1'b0;
   logic       exp_sf  = 1'b0;
   logic       exp_vf  = 1'b0;
   logic       exp_ov  = 1'b0;

   alu4 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ctl       (ctl),
      .in1       (in1),
      .in2       (in2),
      .in_valid  (in_valid),
      .out       (out),
      .ZF        (zf),
      .CF        (cf),
      .SF        (sf),
`ifdef ALU4_VF_EN
      .VF        (vf),
`endif
      .out_valid (out_valid)
   );

`ifndef ALU4_VF_EN
   assign vf = 1'b0;
`endif

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the opcode's meaning.
   task automatic ref_op(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] r, output logic fc, output logic fv);
      int ua, ub, sa, sb, ures, sres;
      logic carry, borrow, v;
      ua     = int'(a);
      ub     = int'(b);
      sa     = (ua >= 8) ? ua - 16 : ua;
      sb     = (ub >= 8) ? ub - 16 : ub;
      ures   = c[0] ? ua - ub : ua + ub;
      sres   = c[0] ? sa - sb : sa + sb;
      r      = 4'((ures + 32) % 16);
      carry  = (ua + ub) > 15;
      borrow = ua < ub;
      v      = (sres < -8) || (sres > 7);
`ifdef ALU4_VF_EN
      fc = c[0] ? borrow : carry;
      fv = c[1] ? v : 1'b0;
`else
      fc = c[1] ? v : (c[0] ? borrow : carry);
      fv = 1'b0;
`endif
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".out"},       out,           exp_out);
      chk({tag, ".zf"},        4'(zf),        4'(exp_zf));
      chk({tag, ".cf"},        4'(cf),        4'(exp_cf));
      chk({tag, ".sf"},        4'(sf),        4'(exp_sf));
      chk({tag, ".out_valid"}, 4'(out_valid), 4'(exp_ov));
`ifdef ALU4_VF_EN
      chk({tag, ".vf"},        4'(vf),        4'(exp_vf));
`endif
   endtask

   task automatic clear_model();
      exp_out = 4'd0;
      exp_zf  = 1'b0;
      exp_cf  = 1'b0;
      exp_sf  = 1'b0;
      exp_vf  = 1'b0;
      exp_ov  = 1'b0;
   endtask

   // Drive one cycle of stimulus, then check the registered outputs.
   task automatic step(input string tag, input logic v, input logic [1:0] c,
                       input logic [3:0] a, input logic [3:0] b);
      logic [3:0] r;
      logic       fc, fv;
      @(negedge clk);
      in_valid = v;
      ctl      = c;
      in1      = a;
      in2      = b;
      @(posedge clk);
      if (v) begin
         ref_op(c, a, b, r, fc, fv);
         exp_out = r;
         exp_zf  = (r == 4'd0);
         exp_cf  = fc;
         exp_sf  = (r >= 4'd8);
         exp_vf  = fv;
      end
      exp_ov = v;
      #1;
      check_all(tag);
   endtask

   initial begin
      clk      = 1'b0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      ctl      = 2'd0;
      in1      = 4'd0;
      in2      = 4'd0;

      // reset state
      @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // reference vectors
      step("v030", 1'b1, 2'd0, 4'd3, 4'd13);
      chk("v030.lit_out", out, 4'd0);
      chk("v030.lit_cf", 4'(cf), 4'd1);
      step("v031", 1'b1, 2'd1, 4'd1, 4'd14);
      chk("v031.lit_out", out, 4'd3);
      step("v032", 1'b1, 2'd2, 4'd3, 4'd7);
      chk("v032.lit_out", out, 4'd10);
      step("v033", 1'b1, 2'd3, 4'd2, 4'd5);
      chk("v033.lit_out", out, 4'd13);

      // boundaries: wrap to zero, extreme signed values
      step("usub_zero",  1'b1, 2'd1, 4'd5,  4'd5);
      step("sadd_m8m8",  1'b1, 2'd2, 4'd8,  4'd8);
      step("ssub_m8_1",  1'b1, 2'd3, 4'd8,  4'd1);
      step("ssub_7_m1",  1'b1, 2'd3, 4'd7,  4'd15);
      step("uadd_ff",    1'b1, 2'd0, 4'd15, 4'd15);
      step("usub_0_15",  1'b1, 2'd1, 4'd0,  4'd15);

      // hold on idle
      step("idle0", 1'b0, 2'd0, 4'd1, 4'd1);
      step("idle1", 1'b0, 2'd3, 4'd9, 4'd2);

      // asynchronous reset between edges with an op in flight
      step("pre_rst", 1'b1, 2'd2, 4'd3, 4'd4);
      @(negedge clk);
      in_valid = 1'b1;
      ctl      = 2'd0;
      in1      = 4'd9;
      in2      = 4'd9;
      #2;
      rst_n = 1'b0;
      #1;
      clear_model();
      check_all("async_rst");
      @(posedge clk);
      #1;
      check_all("rst_held");
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      step("post_rst0", 1'b0, 2'd0, 4'd9, 4'd9);
      step("post_rst1", 1'b0, 2'd1, 4'd9, 4'd2);
      step("first_op",  1'b1, 2'd0, 4'd4, 4'd4);

      // back-to-back burst then idle: last result must stay
      step("b2b0", 1'b1, 2'd0, 4'd1, 4'd2);
      step("b2b1", 1'b1, 2'd1, 4'd2, 4'd7);
      step("b2b2", 1'b1, 2'd2, 4'd6, 4'd5);
      step("b2b3", 1'b1, 2'd3, 4'd9, 4'd3);
      step("b2b_idle0", 1'b0, 2'd0, 4'd0, 4'd0);
      step("b2b_idle1", 1'b0, 2'd1, 4'd15, 4'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu4.md
ALU4 -- requirements
Module: alu4

Interface
REQ-001 No parameters; datapath width fixed at 4 bits, opcode width fixed at 2 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ctl  input  2  opcode: 0 unsigned add, 1 unsigned sub, 2 signed add, 3 signed sub.
REQ-005 in1  input  4  operand A (two's complement when ctl[1]=1).
REQ-006 in2  input  4  operand B (two's complement when ctl[1]=1).
REQ-007 in_valid  input  1  operands/opcode valid this cycle.
REQ-008 out  output  4  registered result.
REQ-009 ZF  output  1  registered zero flag.
REQ-010 CF  output  1  registered carry/borrow/overflow flag (see Function).
REQ-011 SF  output  1  registered sign flag.
REQ-012 out_valid  output  1  result and flags valid.
REQ-013 VF  output  1  registered signed-overflow flag; present only with ALU4_VF_EN.

Function
REQ-014 On a rising clk with in_valid=1, out and all flags SHALL load the result of (ctl, in1, in2); latency exactly 1 cycle.
REQ-015 out_valid SHALL equal in_valid delayed one cycle; back-to-back ops every cycle allowed, no stall.
REQ-016 With in_valid=0, out and flags SHALL hold their previous values; out_valid SHALL go 0.
REQ-017 ctl=0: out = (in1+in2) mod 16; CF = bit 4 of 5-bit unsigned sum.
REQ-018 ctl=1: out = (in1-in2) mod 16; CF = 1 iff in1 < in2 unsigned (borrow).
REQ-019 ctl=2: out = (in1+in2) mod 16; ctl=3: out = (in1-in2) mod 16.
REQ-020 Signed overflow V = 1 iff the true signed result lies outside -8..+7.
REQ-021 ZF = 1 iff out == 0 for every opcode, including wrap to zero.
REQ-022 SF = out[3] for every opcode (raw MSB, not corrected for overflow).
REQ-023 Without ALU4_VF_EN: for ctl=2/3, CF SHALL equal V.
REQ-024 Subtraction SHALL be in1 + ~in2 + 1; identical bit pattern for ctl=1 and ctl=3.

Reset
REQ-025 rst_n low SHALL immediately (asynchronously) force out=0, ZF=0, CF=0, SF=0, out_valid=0, VF=0 if present.
REQ-026 Reset mid-operation SHALL discard the in-flight op; the first op after rst_n rises SHALL complete on its first rising edge.
REQ-027 Deassertion of rst_n is treated as synchronous to clk by the integrator; no internal synchronizer.

Configuration
REQ-028 Macro ALU4_VF_EN defined: VF port exists and carries V for ctl=2/3 (0 for ctl=0/1); CF for ctl=2 is carry-out, for ctl=3 borrow, same rules as ctl=0/1.
REQ-029 ALU4_VF_EN undefined: no VF port; CF behaves per REQ-017, REQ-018, REQ-023.

Verification
REQ-030 ctl=0, in1=3, in2=13, in_valid=1 -> next cycle out=0, CF=1, ZF=1, SF=0, out_valid=1.
REQ-031 ctl=1, in1=1, in2=14 -> out=3, CF=1 (borrow), ZF=0, SF=0.
REQ-032 ctl=2, in1=3, in2=7 -> out=10 (4'b1010), SF=1, ZF=0; CF=1 without macro; with macro CF=0, VF=1.
REQ-033 ctl=3, in1=2, in2=5 -> out=13 (-3), SF=1, ZF=0; CF=0 without macro; with macro CF=1 (borrow), VF=0.
REQ-034 Issue op, assert rst_n low between edges -> outputs 0 immediately, out_valid=0; release, hold in_valid=0 -> outputs stay 0.
REQ-035 Four consecutive in_valid cycles then in_valid=0 -> four out_valid pulses, results in order, last result held afterwards.
